div_result_fixup: RTL
=====================

# div_result_fixup

Signed-result stage directly downstream of the unsigned divider core. Accepts unsigned quotient/remainder magnitudes with the operand sign bits and a divide-by-zero indication, and applies signed truncating-division correction. Also flags the single overflow case. Presents the corrected results as the Z register pair (ZLO = quotient, ZHI = remainder) through a valid/ready handshake. A two-stage pipeline with an output skid buffer sustains one result per cycle under backpressure.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high, clears all state
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept
- in_quotient  input  WIDTH  unsigned quotient magnitude
- in_remainder  input  WIDTH  unsigned remainder magnitude
- in_dividend_neg  input  1  original dividend was negative
- in_divisor_neg  input  1  original divisor was negative
- in_div_by_zero  input  1  divisor was zero
- out_valid  output  1  corrected result valid
- out_ready  input  1  consumer accepts
- z_lo  output  WIDTH  signed quotient
- z_hi  output  WIDTH  signed remainder
- out_dbz  output  1  divide-by-zero flag for this result
- out_ovf  output  1  signed-overflow flag for this result

## Operation
- Transfer on any port occurs when valid && ready on the same rising edge.
- S1 (capture): registers the input bundle on in-transfer.
- S2 (fix-up): computes the corrected result from the S1 contents and registers it.
- Sign rules, truncation toward zero:
  - q_neg = dividend_neg ^ divisor_neg.
  - z_lo = q_neg ? (~in_quotient + 1) : in_quotient.
  - z_hi = dividend_neg ? (~in_remainder + 1) : in_remainder.
  - All arithmetic is modulo 2^WIDTH.
  - Negation of 0 yields 0.
- Divide-by-zero:
  - z_lo forced to all ones (0xFFFFFFFF). Sign rule not applied.
  - z_hi = the signed dividend (the core reports remainder = dividend magnitude).
  - out_dbz = 1, out_ovf = 0.
- Overflow:
  - Condition: q_neg = 0, in_quotient MSB = 1, and not divide-by-zero (e.g. -2^31 / -1).
  - z_lo = 0x80000000, z_hi = 0, out_ovf = 1.
- Flags travel with their result; they are never sticky across results.
- Ordering strictly FIFO. No result is dropped or duplicated.

## Timing
- Reset values: out_valid = 0, z_lo = 0, z_hi = 0, out_dbz = 0, out_ovf = 0.
- in_ready = 0 during reset. in_ready = 1 the first cycle after rst deasserts.
- Reset mid-operation discards all in-flight entries. Outputs take reset values on the next edge.
- Latency: input accepted at edge N. out_valid = 1 after edge N+2 if downstream is not stalled.
- Throughput: one result per cycle while out_ready = 1.
- out_valid/z_lo/z_hi/flags are registered. While out_valid = 1 && out_ready = 0 they hold stable.
- in_ready is registered and is driven from the skid-buffer state only, with no combinational path from out_ready.
- Skid buffer: 2 entries behind S2.
  - in_ready deasserts when the buffer is full, with a stage still occupied.
  - in_ready reasserts the cycle after an output transfer frees an entry.
- Simultaneous in-transfer and out-transfer when full: both complete. Occupancy unchanged.
- Empty: out_valid = 0. z_lo/z_hi hold the last value and are don't-care to consumers.

## Structure
- Shared package div_pkg holds:
  - WIDTH default.
  - DBZ_QUOTIENT constant (all ones).
  - OVF_QUOTIENT constant (MSB only).
  - Typedef div_result_t bundling quotient, remainder, dbz, ovf.
- The same package is used by the divider core and the Z-register writeback.
- One sub-module: div_skid_buffer.
  - Parameterised on the div_result_t payload.
  - 2-entry valid/ready buffer with registered ready.
- Sign fix-up logic stays inline in div_result_fixup.

## Test plan
- 7 / -2: quotient 3, remainder 1, dividend_neg 0, divisor_neg 1 -> z_lo 0xFFFFFFFD, z_hi 1, flags 0, out_valid exactly 2 edges after accept.
- -7 / 2: quotient 3, remainder 1, dividend_neg 1 -> z_lo 0xFFFFFFFD, z_hi 0xFFFFFFFF.
- Divide-by-zero with dividend -5: remainder mag 5, dbz 1 -> z_lo 0xFFFFFFFF, z_hi 0xFFFFFFFB, out_dbz 1, out_ovf 0.
- Overflow: quotient 0x80000000, both neg, remainder 0 -> z_lo 0x80000000, z_hi 0, out_ovf 1.
- Backpressure: stream 6 back-to-back results with out_ready low for 4 cycles.
  - in_ready drops once 4 entries are held.
  - All 6 results emerge in order, with outputs stable while stalled.
- Reset asserted with 3 entries in flight -> out_valid 0 next edge, in_ready 1 after release, no stale result ever emitted.

Source files
------------

// File: rtl/div_pkg.sv
// Shared divider definitions: result width, special quotient encodings and
// the bundles passed between the divider core, fix-up stage and Z writeback.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;
  localparam logic [DIV_WIDTH-1:0] OVF_QUOTIENT = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 dbz;
    logic                 ovf;
  } div_result_t;

  // Unsigned magnitudes plus operand signs, as reported by the core.
  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 dividend_neg;
    logic                 divisor_neg;
    logic                 div_by_zero;
  } div_raw_t;

  function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] v);
    return ~v + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/div_result_fixup_if.sv
// Valid/ready bundle between the divider core, the fix-up stage and the
// Z-register consumer.
interface div_result_fixup_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_quotient;
  logic [WIDTH-1:0] in_remainder;
  logic             in_dividend_neg;
  logic             in_divisor_neg;
  logic             in_div_by_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z_lo;
  logic [WIDTH-1:0] z_hi;
  logic             out_dbz;
  logic             out_ovf;

  modport master (
    output in_valid, in_quotient, in_remainder, in_dividend_neg,
           in_divisor_neg, in_div_by_zero, out_ready,
    input  in_ready, out_valid, z_lo, z_hi, out_dbz, out_ovf
  );

  modport slave (
    input  in_valid, in_quotient, in_remainder, in_dividend_neg,
           in_divisor_neg, in_div_by_zero, out_ready,
    output in_ready, out_valid, z_lo, z_hi, out_dbz, out_ovf
  );

endinterface

// File: rtl/div_skid_buffer.sv
// Two-entry valid/ready buffer with registered ready and registered output;
// the head entry drives the consumer directly.
module div_skid_buffer
  import div_pkg::*;
#(
  parameter type payload_t = div_result_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_valid,
  input  payload_t push_data,
  output logic     push_ready,
  output logic     push_ready_next,
  output logic     pop_valid,
  input  logic     pop_ready,
  output payload_t pop_data
);

  logic [1:0] count;
  logic [1:0] count_next;
  logic       push;
  logic       pop;
  payload_t   tail;

  assign push            = push_valid && push_ready;
  assign pop             = pop_valid && pop_ready;
  assign count_next      = count + 2'(push) - 2'(pop);
  assign push_ready_next = (count_next != 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      pop_valid  <= 1'b0;
      push_ready <= 1'b0;
      pop_data   <= '0;
    end else begin
      count      <= count_next;
      pop_valid  <= (count_next != 2'd0);
      push_ready <= push_ready_next;
      // A full buffer never pushes, so the head refills from either the tail
      // or the incoming entry, never both.
      if (pop && count == 2'd2)
        pop_data <= tail;
      else if (push && (count == 2'd0 || pop))
        pop_data <= push_data;
    end
  end

  // NOTE: the tail is pure storage gated by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && count == 2'd1 && !pop)
      tail <= push_data;
  end

endmodule

// File: rtl/div_result_fixup.sv
// Signed-result stage behind the unsigned divider core: capture, sign fix-up
// with divide-by-zero / overflow handling, then a skid buffer to the Z pair.
module div_result_fixup
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic               clk,
  input logic               rst,
  div_result_fixup_if.slave bus
);

  logic        s1_valid;
  logic        s1_valid_next;
  div_raw_t    s1;
  div_raw_t    in_raw;
  logic        s2_valid;
  logic        s2_valid_next;
  div_result_t s2;
  div_result_t fix;
  div_result_t head;
  logic        q_neg;
  logic        in_xfer;
  logic        s1_fwd;
  logic        s2_adv;
  logic        buf_ready;
  logic        buf_ready_next;
  logic        in_ready_q;

  assign in_raw = '{quotient:     bus.in_quotient,
                    remainder:    bus.in_remainder,
                    dividend_neg: bus.in_dividend_neg,
                    divisor_neg:  bus.in_divisor_neg,
                    div_by_zero:  bus.in_div_by_zero};

  assign in_xfer       = bus.in_valid && in_ready_q;
  assign s2_adv        = s2_valid && buf_ready;
  assign s1_fwd        = s1_valid && (!s2_valid || s2_adv);
  assign s1_valid_next = in_xfer || (s1_valid && !s1_fwd);
  assign s2_valid_next = s1_fwd || (s2_valid && !s2_adv);

  assign q_neg = s1.dividend_neg ^ s1.divisor_neg;

  // NOTE: every field gets a value on every path so no latch is inferred.
  always_comb begin
    fix.quotient  = q_neg ? negate(s1.quotient) : s1.quotient;
    fix.remainder = s1.dividend_neg ? negate(s1.remainder) : s1.remainder;
    fix.dbz       = 1'b0;
    fix.ovf       = 1'b0;
    if (s1.div_by_zero) begin
      fix.quotient = DBZ_QUOTIENT;
      fix.dbz      = 1'b1;
    end else if (!q_neg && s1.quotient[WIDTH-1]) begin
      // Only a positive result of magnitude 2^(WIDTH-1) is unrepresentable.
      fix.quotient  = OVF_QUOTIENT;
      fix.remainder = '0;
      fix.ovf       = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every stage samples
  // the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1         <= '0;
      s2         <= '0;
      in_ready_q <= 1'b0;
    end else begin
      s1_valid <= s1_valid_next;
      s2_valid <= s2_valid_next;
      // Ready is recomputed from next-cycle occupancy, keeping out_ready off
      // any combinational path to in_ready.
      in_ready_q <= !(s1_valid_next && s2_valid_next && !buf_ready_next);
      if (in_xfer) s1 <= in_raw;
      if (s1_fwd)  s2 <= fix;
    end
  end

  div_skid_buffer #(
    .payload_t(div_result_t)
  ) u_skid (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (s2_valid),
    .push_data      (s2),
    .push_ready     (buf_ready),
    .push_ready_next(buf_ready_next),
    .pop_valid      (bus.out_valid),
    .pop_ready      (bus.out_ready),
    .pop_data       (head)
  );

  assign bus.in_ready = in_ready_q;
  assign bus.z_lo     = head.quotient;
  assign bus.z_hi     = head.remainder;
  assign bus.out_dbz  = head.dbz;
  assign bus.out_ovf  = head.ovf;

endmodule
